// File: rtl/rv0_bru_pkg.sv
// rv0_bru_pkg: shared opcode/funct3 encodings and the branch resolution record
//   rv_opcode_e    - major opcodes of interest to the branch unit
//   br_funct3_e    - BRANCH condition encodings
//   bru_res_t      - resolution record (fields sized for the widest XLEN)
//   is_ct()        - true for JAL/JALR/BRANCH opcodes
package rv0_bru_pkg;

    localparam int RES_W = 64;

    typedef enum logic [6:0] {
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_OP_IMM = 7'b0010011
    } rv_opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    typedef struct packed {
        logic             wen;
        logic [RES_W-1:0] wdata;
        logic             taken;
        logic [RES_W-1:0] target;
        logic             mispred;
        logic [RES_W-1:0] redirect;
        logic             exc;
    } bru_res_t;

    function automatic logic is_ct(input logic [6:0] opc);
        return opc == OPC_JAL || opc == OPC_JALR || opc == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/rv0_bru_eval.sv
// rv0_bru_eval: combinational control-transfer evaluation
//   insn_i/addr_i/rs1_i/rs2_i       - instruction, PC and operands
//   pred_taken_i/pred_target_i      - front-end prediction
//   res_o                           - resolved link data, target, taken, mispredict, exception
// Optional: RV0_BRU_MISALIGN_EXC_EN enables the instruction-address-misaligned exception.
module rv0_bru_eval
    import rv0_bru_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic [31:0]     insn_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output bru_res_t        res_o
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_j, imm_i, imm_b, pc4, jalr_sum, tgt;
    logic            is_jal, is_jalr, is_br, eq, lt, ltu, cond, taken, mis, exc, mp;

    assign opc      = insn_i[6:0];
    assign f3       = insn_i[14:12];
    assign imm_j    = {{(XLEN-21){insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
    assign imm_i    = {{(XLEN-12){insn_i[31]}}, insn_i[31:20]};
    assign imm_b    = {{(XLEN-13){insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
    assign is_jal   = opc == OPC_JAL;
    assign is_jalr  = opc == OPC_JALR;
    assign is_br    = opc == OPC_BRANCH;
    assign pc4      = addr_i + XLEN'(4);
    assign jalr_sum = rs1_i + imm_i;
    assign tgt      = is_jal  ? addr_i + imm_j :
                      is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} :
                      is_br   ? addr_i + imm_b : '0;
    assign eq       = rs1_i == rs2_i;
    assign lt       = $signed(rs1_i) < $signed(rs2_i);
    assign ltu      = rs1_i < rs2_i;
    // Reserved funct3 010/011 fall through to not-taken
    assign cond     = f3 == F3_BEQ  ? eq  :
                      f3 == F3_BNE  ? !eq :
                      f3 == F3_BLT  ? lt  :
                      f3 == F3_BGE  ? !lt :
                      f3 == F3_BLTU ? ltu :
                      f3 == F3_BGEU ? !ltu : 1'b0;
    assign taken    = is_jal || is_jalr || (is_br && cond);
    // Bit 0 of every target is already zero, so only IALIGN=32 can misalign
    assign mis      = (IALIGN == 32) && tgt[1];
`ifdef RV0_BRU_MISALIGN_EXC_EN
    assign exc      = taken && mis;
`else
    logic unused_mis;
    assign unused_mis = mis;
    assign exc      = 1'b0;
`endif
    assign mp       = !exc && ((taken != pred_taken_i) || (taken && tgt != pred_target_i));

    always_comb begin
        res_o          = '0;
        res_o.wen      = (is_jal || is_jalr) && !exc;
        res_o.wdata    = (is_jal || is_jalr) ? RES_W'(pc4) : '0;
        res_o.taken    = taken;
        res_o.target   = RES_W'(tgt);
        res_o.mispred  = mp;
        res_o.redirect = taken ? RES_W'(tgt) : RES_W'(pc4);
        res_o.exc      = exc;
    end

endmodule

// File: rtl/rv0_bru.sv
// rv0_bru: pipelined branch/jump resolution unit with valid/ready handshake
//   clk_i, rst_ni                     - clock, async active-low reset
//   bru_flush_i                       - kill in-flight and incoming op
//   bru_valid_i/bru_ready_o           - op input handshake
//   bru_insn_i..bru_pred_target_i     - instruction, PC, operands, prediction
//   bru_valid_o/bru_ready_i           - resolution output handshake
//   bru_wen_o..bru_exc_o              - registered resolution
//   bru_br_cnt_o/bru_mp_cnt_o         - saturating resolved/mispredicted counters
// Optional: RV0_BRU_MISALIGN_EXC_EN (see rv0_bru_eval).
module rv0_bru
    import rv0_bru_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bru_flush_i,
    input  logic             bru_valid_i,
    output logic             bru_ready_o,
    input  logic [31:0]      bru_insn_i,
    input  logic [XLEN-1:0]  bru_addr_i,
    input  logic [XLEN-1:0]  bru_rdata1_i,
    input  logic [XLEN-1:0]  bru_rdata2_i,
    input  logic             bru_pred_taken_i,
    input  logic [XLEN-1:0]  bru_pred_target_i,
    output logic             bru_valid_o,
    input  logic             bru_ready_i,
    output logic             bru_wen_o,
    output logic [XLEN-1:0]  bru_wdata_o,
    output logic             bru_taken_o,
    output logic [XLEN-1:0]  bru_target_o,
    output logic             bru_mispred_o,
    output logic [XLEN-1:0]  bru_redirect_o,
    output logic             bru_exc_o,
    output logic [CNT_W-1:0] bru_br_cnt_o,
    output logic [CNT_W-1:0] bru_mp_cnt_o
);

    bru_res_t         res_d, res_q;
    logic             valid_q, ct_q, accept, hs;
    logic [CNT_W-1:0] br_cnt_d, br_cnt_q, mp_cnt_d, mp_cnt_q;

    rv0_bru_eval #(.XLEN(XLEN), .IALIGN(IALIGN)) u_eval (
        .insn_i        (bru_insn_i),
        .addr_i        (bru_addr_i),
        .rs1_i         (bru_rdata1_i),
        .rs2_i         (bru_rdata2_i),
        .pred_taken_i  (bru_pred_taken_i),
        .pred_target_i (bru_pred_target_i),
        .res_o         (res_d)
    );

    assign bru_ready_o = !valid_q || bru_ready_i;
    assign accept      = bru_valid_i && bru_ready_o && !bru_flush_i;
    // Only control-transfer ops that actually leave the unit are counted
    assign hs          = valid_q && bru_ready_i && !bru_flush_i && ct_q;
    assign br_cnt_d    = (hs && br_cnt_q != '1) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    assign mp_cnt_d    = (hs && res_q.mispred && mp_cnt_q != '1) ? mp_cnt_q + CNT_W'(1) : mp_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            ct_q     <= 1'b0;
            res_q    <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
            if (bru_flush_i) begin
                valid_q <= 1'b0;
                ct_q    <= 1'b0;
                res_q   <= '0;
            end else if (accept) begin
                valid_q <= 1'b1;
                ct_q    <= is_ct(bru_insn_i[6:0]);
                res_q   <= res_d;
            end else if (bru_ready_i) begin
                valid_q <= 1'b0;
                ct_q    <= 1'b0;
                res_q   <= '0;
            end
        end
    end

    assign bru_valid_o    = valid_q;
    assign bru_wen_o      = res_q.wen;
    assign bru_wdata_o    = res_q.wdata[XLEN-1:0];
    assign bru_taken_o    = res_q.taken;
    assign bru_target_o   = res_q.target[XLEN-1:0];
    assign bru_mispred_o  = res_q.mispred;
    assign bru_redirect_o = res_q.redirect[XLEN-1:0];
    assign bru_exc_o      = res_q.exc;
    assign bru_br_cnt_o   = br_cnt_q;
    assign bru_mp_cnt_o   = mp_cnt_q;

    if (XLEN < RES_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{res_q.wdata[RES_W-1:XLEN], res_q.target[RES_W-1:XLEN],
                             res_q.redirect[RES_W-1:XLEN], res_d.wdata[RES_W-1:XLEN],
                             res_d.target[RES_W-1:XLEN], res_d.redirect[RES_W-1:XLEN]};
    end

endmodule

// File: tb/tb_rv0_bru.sv
// tb_rv0_bru: directed table-driven bench for rv0_bru (XLEN=32, IALIGN=32, CNT_W=4)
module tb_rv0_bru;

    typedef struct {
        logic [31:0] insn, pc, rs1, rs2;
        logic        pt;
        logic [31:0] ptgt;
        logic        ct, wen;
        logic [31:0] wdata;
        logic        taken;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] rd;
        logic        exc;
    } vec_t;

    logic        clk = 0, rst_n = 0, flush = 0, vin = 0, rdy_i = 1, pt = 0;
    logic [31:0] insn = 0, pc = 0, rs1 = 0, rs2 = 0, ptgt = 0;
    logic        rdy_o, vout, wen, taken, mp, exc;
    logic [31:0] wdata, tgt, rd;
    logic [3:0]  brc, mpc;
    int          checks = 0, failures = 0;
    int          br_m = 0, mp_m = 0;
    vec_t        v[13];

    always #5 clk = ~clk;

    rv0_bru #(.XLEN(32), .IALIGN(32), .CNT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bru_flush_i(flush), .bru_valid_i(vin), .bru_ready_o(rdy_o),
        .bru_insn_i(insn), .bru_addr_i(pc), .bru_rdata1_i(rs1), .bru_rdata2_i(rs2),
        .bru_pred_taken_i(pt), .bru_pred_target_i(ptgt), .bru_valid_o(vout), .bru_ready_i(rdy_i),
        .bru_wen_o(wen), .bru_wdata_o(wdata), .bru_taken_o(taken), .bru_target_o(tgt),
        .bru_mispred_o(mp), .bru_redirect_o(rd), .bru_exc_o(exc), .bru_br_cnt_o(brc), .bru_mp_cnt_o(mpc)
    );

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_jr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        insn = x.insn; pc = x.pc; rs1 = x.rs1; rs2 = x.rs2; pt = x.pt; ptgt = x.ptgt;
    endtask

    task automatic chk_res(input string n, input vec_t x);
        chk({n, ".valid"}, 32'(vout), 1);
        chk({n, ".wen"}, 32'(wen), 32'(x.wen));
        chk({n, ".wdata"}, wdata, x.wdata);
        chk({n, ".taken"}, 32'(taken), 32'(x.taken));
        chk({n, ".target"}, tgt, x.tgt);
        chk({n, ".mispred"}, 32'(mp), 32'(x.mp));
        chk({n, ".redirect"}, rd, x.rd);
        chk({n, ".exc"}, 32'(exc), 32'(x.exc));
    endtask

    task automatic model(input vec_t x);
        if (x.ct && br_m < 15) br_m++;
        if (x.ct && x.mp && mp_m < 15) mp_m++;
    endtask

    task automatic chk_cnt(input string n);
        chk({n, ".br_cnt"}, 32'(brc), br_m);
        chk({n, ".mp_cnt"}, 32'(mpc), mp_m);
    endtask

    initial begin
        //         insn                         pc           rs1          rs2          pt   ptgt         ct   wen  wdata        tk   tgt          mp   rd           exc
        v[0]  = '{enc_b(3'b000, 13'h020),      32'h100,     32'd5,       32'd5,       1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b1, 32'h120,    1'b1, 32'h120,    1'b0};
        v[1]  = '{enc_b(3'b100, 13'h020),      32'h100,     32'hFFFFFFFF,32'd1,       1'b1, 32'h120,    1'b1, 1'b0, 32'h0,      1'b1, 32'h120,    1'b0, 32'h120,    1'b0};
        v[2]  = '{enc_b(3'b110, 13'h020),      32'h100,     32'hFFFFFFFF,32'd1,       1'b1, 32'h120,    1'b1, 1'b0, 32'h0,      1'b0, 32'h120,    1'b1, 32'h104,    1'b0};
`ifdef RV0_BRU_MISALIGN_EXC_EN
        v[3]  = '{enc_jr(12'h000),             32'h200,     32'h1003,    32'h0,       1'b1, 32'h1002,   1'b1, 1'b0, 32'h204,    1'b1, 32'h1002,   1'b0, 32'h1002,   1'b1};
`else
        v[3]  = '{enc_jr(12'h000),             32'h200,     32'h1003,    32'h0,       1'b1, 32'h1002,   1'b1, 1'b1, 32'h204,    1'b1, 32'h1002,   1'b0, 32'h1002,   1'b0};
`endif
        v[4]  = '{enc_b(3'b001, 13'h1FF8),     32'h40,      32'd5,       32'd5,       1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b0, 32'h38,     1'b0, 32'h44,     1'b0};
        v[5]  = '{enc_b(3'b101, 13'h1FF0),     32'h80,      32'hFFFFFFFF,32'hFFFFFFFF,1'b1, 32'h70,     1'b1, 1'b0, 32'h0,      1'b1, 32'h70,     1'b0, 32'h70,     1'b0};
        v[6]  = '{enc_b(3'b111, 13'h008),      32'h80,      32'd1,       32'hFFFFFFFF,1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b0, 32'h88,     1'b0, 32'h84,     1'b0};
        v[7]  = '{enc_b(3'b010, 13'h008),      32'h80,      32'd3,       32'd3,       1'b1, 32'h88,     1'b1, 1'b0, 32'h0,      1'b0, 32'h88,     1'b1, 32'h84,     1'b0};
        v[8]  = '{enc_j(21'h000800),           32'h1000,    32'h0,       32'h0,       1'b1, 32'h1800,   1'b1, 1'b1, 32'h1004,   1'b1, 32'h1800,   1'b0, 32'h1800,   1'b0};
        v[9]  = '{enc_j(21'h1FFFFC),           32'h0,       32'h0,       32'h0,       1'b1, 32'h10,     1'b1, 1'b1, 32'h4,      1'b1, 32'hFFFFFFFC,1'b1,32'hFFFFFFFC,1'b0};
        v[10] = '{32'h00500093,                32'h300,     32'h0,       32'h0,       1'b1, 32'h400,    1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h304,    1'b0};
        v[11] = '{enc_jr(12'hFF0),             32'h10,      32'h2000,    32'h0,       1'b0, 32'h0,      1'b1, 1'b1, 32'h14,     1'b1, 32'h1FF0,   1'b1, 32'h1FF0,   1'b0};
`ifdef RV0_BRU_MISALIGN_EXC_EN
        v[12] = '{enc_j(21'h000006),           32'h0,       32'h0,       32'h0,       1'b0, 32'h0,      1'b1, 1'b0, 32'h4,      1'b1, 32'h6,      1'b0, 32'h6,      1'b1};
`else
        v[12] = '{enc_j(21'h000006),           32'h0,       32'h0,       32'h0,       1'b0, 32'h0,      1'b1, 1'b1, 32'h4,      1'b1, 32'h6,      1'b1, 32'h6,      1'b0};
`endif
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(vout), 0);
        chk("rst.ready", 32'(rdy_o), 1);
        chk("rst.target", tgt, 0);
        chk("rst.redirect", rd, 0);
        chk_cnt("rst");
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            drive(v[i]); vin = 1; rdy_i = 1;
            @(negedge clk);
            vin = 0;
            chk_res($sformatf("vec%0d", i), v[i]);
            @(negedge clk);
            model(v[i]);
            chk_cnt($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.clear", i), 32'(vout), 0);
        end
        // stall: hold a BEQ result while a different op waits at the input
        drive(v[0]); vin = 1; rdy_i = 0;
        @(negedge clk);
        drive(v[3]);
        for (int c = 0; c < 3; c++) begin
            chk_res($sformatf("stall%0d", c), v[0]);
            chk($sformatf("stall%0d.ready", c), 32'(rdy_o), 0);
            chk_cnt($sformatf("stall%0d", c));
            @(negedge clk);
        end
        vin = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        chk("stallflush.valid", 32'(vout), 0);
        chk_cnt("stallflush");
        // flush drops a same-cycle incoming op
        drive(v[8]); vin = 1; rdy_i = 1; flush = 1;
        @(negedge clk);
        flush = 0; vin = 0;
        chk("flushin.valid", 32'(vout), 0);
        @(negedge clk);
        chk("flushin.valid2", 32'(vout), 0);
        chk_cnt("flushin");
        // back-to-back: one op per cycle
        drive(v[8]); vin = 1;
        @(negedge clk);
        chk_res("b2b0", v[8]);
        chk("b2b0.ready", 32'(rdy_o), 1);
        drive(v[11]);
        @(negedge clk);
        vin = 0;
        model(v[8]);
        chk_res("b2b1", v[11]);
        chk_cnt("b2b1");
        @(negedge clk);
        model(v[11]);
        chk_cnt("b2b2");
        chk("b2b2.valid", 32'(vout), 0);
        // saturation: 20 mispredicted branches
        drive(v[0]); vin = 1;
        repeat (20) @(negedge clk);
        vin = 0;
        repeat (2) @(negedge clk);
        chk("sat.br_cnt", 32'(brc), 32'hF);
        chk("sat.mp_cnt", 32'(mpc), 32'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
